// File: rtl/battleship_pkg.sv
// Shared board geometry, cell/coordinate types and the CPU shot FSM states.
// Coordinate helpers split a linear cell index (row-major) into fila/columna.
package battleship_pkg;

  localparam int BOARD_N = 5;
  localparam int CELLS   = BOARD_N * BOARD_N;

  typedef logic [2:0] coord_t;
  typedef logic [4:0] cell_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    PICK,
    PROBE,
    ISSUE,
    WAIT,
    FULL
  } state_t;

  function automatic coord_t row_of(input cell_idx_t idx);
    return coord_t'(idx / 5'(BOARD_N));
  endfunction

  function automatic coord_t col_of(input cell_idx_t idx);
    return coord_t'(idx % 5'(BOARD_N));
  endfunction

  // Linear probing walks the board in index order and wraps after the last cell.
  function automatic cell_idx_t next_cell(input cell_idx_t idx);
    return (idx == 5'(CELLS - 1)) ? '0 : idx + 5'd1;
  endfunction

endpackage

// File: rtl/lfsr5.sv
// 5-bit Fibonacci LFSR for x^5+x^3+1 (period 31), reloaded with SEED on reset.
module lfsr5 #(
  parameter logic [4:0] SEED = 5'b00011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_i,
  output logic [4:0] state_o
);

  logic [4:0] lfsr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= SEED;
    end else if (step_i) begin
      lfsr_q <= {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/cpu_shot_issuer.sv
// CPU opponent turn engine: picks an unfired cell from an LFSR (probing past
// already-fired cells), offers it to the board registry and tracks the replies.
module cpu_shot_issuer
  import battleship_pkg::*;
#(
  parameter logic [4:0] SEED         = 5'b00011,
  parameter int         RESP_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       new_game,
  input  logic       shot_ready,
  input  logic       resp_valid,
  input  logic       resp_accept,
  output logic       shot_valid,
  output logic [2:0] fila,
  output logic [2:0] columna,
  output logic       done,
  output logic [4:0] shots_used,
  output logic       board_full
);

  localparam int TMO_W = $clog2(RESP_TIMEOUT) + 1;

  state_t           state_q;
  logic [CELLS-1:0] mask_q;
  logic [CELLS-1:0] mask_d;
  cell_idx_t        idx_q;
  cell_idx_t        cand;
  coord_t           fila_q;
  coord_t           columna_q;
  logic             shot_valid_q;
  logic             done_q;
  logic             board_full_q;
  logic [4:0]       shots_used_q;
  logic [4:0]       shots_used_d;
  logic [TMO_W-1:0] tmo_q;
  logic [4:0]       lfsr_v;
  logic             lfsr_step;
  logic             cand_valid;
  logic             cand_free;
  logic             probe_free;

  assign cand         = lfsr_v - 5'd1;
  assign cand_valid   = (lfsr_v <= 5'(CELLS));
  assign cand_free    = !mask_q[cand];
  assign probe_free   = !mask_q[idx_q];
  assign mask_d       = mask_q | ({{(CELLS-1){1'b0}}, 1'b1} << idx_q);
  assign shots_used_d = (shots_used_q == 5'(CELLS)) ? shots_used_q : shots_used_q + 5'd1;

  // The LFSR advances past out-of-range values and once per latched candidate,
  // so a masked candidate consumes its value only when probing settles.
  always_comb begin
    lfsr_step = 1'b0;
    if (state_q == PICK) begin
      lfsr_step = !cand_valid || cand_free;
    end else if (state_q == PROBE) begin
      lfsr_step = probe_free;
    end
  end

  lfsr5 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .step_i (lfsr_step),
    .state_o(lfsr_v)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      idx_q        <= '0;
      fila_q       <= '0;
      columna_q    <= '0;
      shot_valid_q <= 1'b0;
      done_q       <= 1'b0;
      shots_used_q <= '0;
      board_full_q <= 1'b0;
      tmo_q        <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (new_game) begin
            mask_q       <= '0;
            shots_used_q <= '0;
          end else if (start) begin
            state_q <= PICK;
          end
        end

        PICK: begin
          if (cand_valid) begin
            idx_q <= cand;
            if (cand_free) begin
              fila_q       <= row_of(cand);
              columna_q    <= col_of(cand);
              shot_valid_q <= 1'b1;
              state_q      <= ISSUE;
            end else begin
              state_q <= PROBE;
            end
          end
        end

        PROBE: begin
          if (probe_free) begin
            fila_q       <= row_of(idx_q);
            columna_q    <= col_of(idx_q);
            shot_valid_q <= 1'b1;
            state_q      <= ISSUE;
          end else begin
            idx_q <= next_cell(idx_q);
          end
        end

        ISSUE: begin
          if (shot_ready) begin
            shot_valid_q <= 1'b0;
            tmo_q        <= '0;
            state_q      <= WAIT;
          end
        end

        // Any reply marks the cell fired; once every cell is fired there is
        // nothing left to pick, so the board is reported full.
        WAIT: begin
          if (resp_valid) begin
            mask_q <= mask_d;
            tmo_q  <= '0;
            if (resp_accept) begin
              done_q       <= 1'b1;
              shots_used_q <= shots_used_d;
            end
            if (&mask_d) begin
              board_full_q <= 1'b1;
              state_q      <= FULL;
            end else begin
              state_q <= resp_accept ? IDLE : PICK;
            end
          end else if (tmo_q == TMO_W'(RESP_TIMEOUT - 1)) begin
            tmo_q        <= '0;
            shot_valid_q <= 1'b1;
            state_q      <= ISSUE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        FULL: begin
          if (new_game) begin
            mask_q       <= '0;
            shots_used_q <= '0;
            board_full_q <= 1'b0;
            state_q      <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign shot_valid = shot_valid_q;
  assign fila       = fila_q;
  assign columna    = columna_q;
  assign done       = done_q;
  assign shots_used = shots_used_q;
  assign board_full = board_full_q;

endmodule

// File: tb/tb_cpu_shot_issuer.sv
// Bench for cpu_shot_issuer: acts as the board registry with random timing and
// predicts every shot from a cell-set model of the picking rules.
module tb_cpu_shot_issuer;

  localparam logic [4:0] SEED         = 5'b00011;
  localparam int         RESP_TIMEOUT = 16;
  localparam int         CELLS        = 25;

  logic       clk;
  logic       reset;
  logic       start;
  logic       newGame;
  logic       shotReady;
  logic       respValid;
  logic       respAccept;
  logic       shotValid;
  logic [2:0] fila;
  logic [2:0] columna;
  logic       done;
  logic [4:0] shotsUsed;
  logic       boardFull;

  int total = 0;
  int bad   = 0;

  bit [CELLS-1:0] mMask;
  int             mLfsr;
  int             mShots;

  cpu_shot_issuer #(
    .SEED        (SEED),
    .RESP_TIMEOUT(RESP_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .new_game   (newGame),
    .shot_ready (shotReady),
    .resp_valid (respValid),
    .resp_accept(respAccept),
    .shot_valid (shotValid),
    .fila       (fila),
    .columna    (columna),
    .done       (done),
    .shots_used (shotsUsed),
    .board_full (boardFull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input bit st, input bit ng, input bit rdy, input bit rv, input bit ra);
    start      = st;
    newGame    = ng;
    shotReady  = rdy;
    respValid  = rv;
    respAccept = ra;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int lfsrNext(input int v);
    return ((v << 1) & 31) | (((v >> 4) ^ (v >> 2)) & 1);
  endfunction

  // Next cell the CPU should fire at: first usable LFSR value names a cell,
  // and if that cell was already fired take the next free one in index order.
  function automatic int modelPick();
    int idx;
    int guard;
    while (mLfsr > CELLS) mLfsr = lfsrNext(mLfsr);
    idx   = mLfsr - 1;
    mLfsr = lfsrNext(mLfsr);
    guard = 0;
    while (mMask[idx] && guard < CELLS) begin
      idx = (idx + 1) % CELLS;
      guard++;
    end
    return idx;
  endfunction

  task automatic waitShot();
    int n;
    n = 0;
    while (shotValid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("shot_arrives", shotValid, 1);
  endtask

  // Serve one offered shot: hold off ready, handshake, optionally let the
  // reply time out once, then answer accept/reject.
  task automatic serveShot(input int expIdx, input bit accept, input int readyDelay,
                           input bit doTimeout, input int respDelay);
    int n;
    checkOutput("shot_fila", fila, expIdx / 5);
    checkOutput("shot_columna", columna, expIdx % 5);
    for (int i = 0; i < readyDelay; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("hold_valid", shotValid, 1);
      checkOutput("hold_fila", fila, expIdx / 5);
      checkOutput("hold_columna", columna, expIdx % 5);
    end
    applyStimulus(0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("valid_drop", shotValid, 0);
    applyStimulus(0, 0, 0, 0, 0);
    if (doTimeout) begin
      n = 0;
      while (shotValid !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      checkOutput("reissue_cycles", n, RESP_TIMEOUT);
      checkOutput("reissue_fila", fila, expIdx / 5);
      checkOutput("reissue_columna", columna, expIdx % 5);
      applyStimulus(0, 0, 1, 0, 0);
      @(negedge clk);
      checkOutput("reissue_drop", shotValid, 0);
      applyStimulus(0, 0, 0, 0, 0);
    end
    repeat (respDelay) @(negedge clk);
    applyStimulus(0, 0, 0, 1, accept);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0);
    mMask[expIdx] = 1'b1;
    if (accept && mShots < CELLS) mShots++;
    checkOutput("done_pulse", done, accept);
    checkOutput("shots_used", shotsUsed, mShots);
    checkOutput("board_full", boardFull, mMask == '1);
  endtask

  task automatic runTurn(input int rejects, input bit doTimeout);
    int expIdx;
    expIdx = modelPick();
    applyStimulus(1, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0);
    for (int r = 0; r <= rejects; r++) begin
      waitShot();
      serveShot(expIdx, r == rejects, $urandom_range(0, 3), doTimeout && (r == 0),
                $urandom_range(0, 10));
      if (r < rejects) expIdx = modelPick();
    end
    @(negedge clk);
    checkOutput("done_clear", done, 0);
  endtask

  initial begin
    int expIdx;
    int cellNow;
    bit sawValid;

    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    mLfsr  = SEED;
    mMask  = '0;
    mShots = 0;
    #1;
    checkOutput("rst_valid", shotValid, 0);
    checkOutput("rst_fila", fila, 0);
    checkOutput("rst_columna", columna, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_shots", shotsUsed, 0);
    checkOutput("rst_full", boardFull, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // First turn from SEED=3: cell 2 offered two edges after start, then rejected.
    expIdx = modelPick();
    applyStimulus(1, 0, 1, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("first_valid", shotValid, 1);
    checkOutput("first_fila", fila, 0);
    checkOutput("first_columna", columna, 2);
    serveShot(expIdx, 0, 0, 0, 2);
    expIdx = modelPick();
    waitShot();
    cellNow = fila * 5 + columna;
    checkOutput("reject_new_cell", cellNow != 2, 1);
    serveShot(expIdx, 1, 3, 0, 4);
    @(negedge clk);
    checkOutput("done_clear", done, 0);

    runTurn(0, 1);
    for (int t = 0; t < 6; t++) runTurn($urandom_range(0, 1), 0);

    // Reset while waiting for a reply abandons the shot entirely.
    expIdx = modelPick();
    applyStimulus(1, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0);
    waitShot();
    checkOutput("pre_rst_fila", fila, expIdx / 5);
    checkOutput("pre_rst_columna", columna, expIdx % 5);
    applyStimulus(0, 0, 1, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midwait_rst_valid", shotValid, 0);
    checkOutput("midwait_rst_done", done, 0);
    checkOutput("midwait_rst_shots", shotsUsed, 0);
    checkOutput("midwait_rst_full", boardFull, 0);
    checkOutput("midwait_rst_fila", fila, 0);
    checkOutput("midwait_rst_columna", columna, 0);
    mLfsr  = SEED;
    mMask  = '0;
    mShots = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    runTurn(0, 0);

    // new_game wins over a simultaneous start.
    applyStimulus(1, 1, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0);
    mMask  = '0;
    mShots = 0;
    checkOutput("ng_shots", shotsUsed, 0);
    sawValid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (shotValid === 1'b1) sawValid = 1'b1;
    end
    checkOutput("ng_priority", sawValid, 0);

    for (int t = 0; t < CELLS; t++) runTurn(0, t == 7);
    checkOutput("full_flag", boardFull, 1);
    checkOutput("full_shots", shotsUsed, 25);

    applyStimulus(1, 0, 1, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 1, 0, 0);
    sawValid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (shotValid === 1'b1) sawValid = 1'b1;
    end
    checkOutput("full_ignores_start", sawValid, 0);
    checkOutput("full_hold", boardFull, 1);
    checkOutput("full_hold_shots", shotsUsed, 25);

    applyStimulus(0, 1, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0);
    mMask  = '0;
    mShots = 0;
    checkOutput("ng_full_clear", boardFull, 0);
    checkOutput("ng_full_shots", shotsUsed, 0);
    runTurn(1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
